// File: rtl/ace_req_if.sv
// ace_req_if: requester, command and status signals between the ACE request arbiter and its environment.
interface ace_req_if;
    logic       req0_valid, req1_valid;
    logic [1:0] req0_op, req1_op;
    logic       req0_ready, req1_ready;
    logic       req0_done, req1_done;
    logic       req0_err, req1_err;
    logic       read_req, write_req, invalid_req;
    logic       ace_ready;
    logic       busy, grant_id;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, ace_ready,
        output req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err,
               read_req, write_req, invalid_req, busy, grant_id
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, ace_ready,
        input  req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err,
               read_req, write_req, invalid_req, busy, grant_id
    );
endinterface

// File: rtl/ace_req_arbiter.sv
// ace_req_arbiter: round-robin arbiter issuing one ACE command at a time from two requesters,
// with a bounded wait for controller completion.
module ace_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic        clk,
    input logic        rst,
    ace_req_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t     state;
    logic [1:0] op;
    logic [7:0] timer;
    logic       last, gnt, take, expire;
    logic [1:0] gop;

    always_comb begin
        gnt    = (bus.req0_valid && bus.req1_valid) ? !last : bus.req1_valid;
        take   = !rst && state == IDLE && (bus.req0_valid || bus.req1_valid);
        gop    = gnt ? bus.req1_op : bus.req0_op;
        expire = (timer + 8'd1) == 8'(TIMEOUT_CYCLES);
    end

    assign bus.req0_ready  = take && !gnt;
    assign bus.req1_ready  = take && gnt;
    // Command pulses decode the latched op only while in ISSUE, so at most one is ever high.
    assign bus.read_req    = state == ISSUE && op == 2'b00;
    assign bus.write_req   = state == ISSUE && op == 2'b01;
    assign bus.invalid_req = state == ISSUE && op == 2'b10;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            op            <= 2'b00;
            timer         <= 8'd0;
            last          <= 1'b1;
            bus.grant_id  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;
            bus.req0_err  <= 1'b0;
            bus.req1_err  <= 1'b0;
        end else begin
            bus.req0_done <= 1'b0;
            bus.req1_done <= 1'b0;
            bus.req0_err  <= 1'b0;
            bus.req1_err  <= 1'b0;
            case (state)
                IDLE: if (take) begin
                    op           <= gop;
                    bus.grant_id <= gnt;
                    bus.busy     <= 1'b1;
                    if (gop == 2'b11) begin
                        state         <= DONE;
                        bus.req0_done <= !gnt;
                        bus.req1_done <= gnt;
                        bus.req0_err  <= !gnt;
                        bus.req1_err  <= gnt;
                    end else begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= 8'd0;
                    state <= WAIT;
                end
                // Completion takes priority over a timeout landing in the same cycle.
                WAIT: if (bus.ace_ready || expire) begin
                    state         <= DONE;
                    bus.req0_done <= !bus.grant_id;
                    bus.req1_done <= bus.grant_id;
                    bus.req0_err  <= !bus.ace_ready && !bus.grant_id;
                    bus.req1_err  <= !bus.ace_ready && bus.grant_id;
                end else begin
                    timer <= timer + 8'd1;
                end
                DONE: begin
                    last     <= bus.grant_id;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ace_req_arbiter.sv
// tb_ace_req_arbiter: directed scenarios; expected events are queued by the stimulus and
// matched by an independent monitor sampling on the falling edge.
module tb_ace_req_arbiter;
    localparam int K_RDY = 0, K_RD = 1, K_WR = 2, K_INV = 3, K_DONE = 4;

    typedef struct {int kind; int id; int err; int cyc;} ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   mon_checks = 0, mon_errors = 0, dir_checks = 0, dir_errors = 0;
    ev_t  q[$];

    ace_req_if bus();
    ace_req_arbiter #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(input int k, input int id, input int e, input int cy);
        q.push_back('{k, id, e, cy});
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        dir_checks++;
        if (act != exp) begin
            dir_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got(input int k, input int id, input int e);
        ev_t x;
        mon_checks++;
        if (q.size() == 0) begin
            mon_errors++;
            $display("FAIL unexpected_event: got kind=%0d id=%0d err=%0d at cycle %0d, expected none", k, id, e, cyc);
        end else begin
            x = q.pop_front();
            if (x.kind != k || x.id != id || x.err != e || x.cyc != cyc) begin
                mon_errors++;
                $display("FAIL event: got kind=%0d id=%0d err=%0d cycle=%0d, expected kind=%0d id=%0d err=%0d cycle=%0d",
                         k, id, e, cyc, x.kind, x.id, x.err, x.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req0_ready)  got(K_RDY, 0, 0);
            if (bus.req1_ready)  got(K_RDY, 1, 0);
            if (bus.read_req)    got(K_RD, int'(bus.grant_id), 0);
            if (bus.write_req)   got(K_WR, int'(bus.grant_id), 0);
            if (bus.invalid_req) got(K_INV, int'(bus.grant_id), 0);
            if (bus.req0_done)   got(K_DONE, 0, int'(bus.req0_err));
            if (bus.req1_done)   got(K_DONE, 1, int'(bus.req1_err));
            if ((bus.req0_err && !bus.req0_done) || (bus.req1_err && !bus.req1_done))
                got(K_DONE, 9, 1);
        end
    end

    function automatic int outs();
        return int'({bus.req0_ready, bus.req1_ready, bus.req0_done, bus.req1_done, bus.req0_err,
                     bus.req1_err, bus.read_req, bus.write_req, bus.invalid_req, bus.busy, bus.grant_id});
    endfunction

    initial begin
        int c;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b0;
        bus.req0_op = 2'b00;
        bus.req1_op = 2'b00;
        bus.ace_ready = 1'b0;
        tick(2);
        chk("reset_outputs", outs(), 0);
        bus.req0_valid = 1'b0;
        rst = 1'b0;
        tick(1);

        // Both requesters writing continuously, ace_ready held high: grants alternate 0,1,0,1.
        c = cyc;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01;
        bus.ace_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            push(K_RDY, k % 2, 0, c + 4 * k);
            push(K_WR, k % 2, 0, c + 4 * k + 1);
            push(K_DONE, k % 2, 0, c + 4 * k + 3);
        end
        tick(13);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        tick(3);
        bus.ace_ready = 1'b0;
        chk("alt_idle_busy", int'(bus.busy), 0);

        // req0 read, ace_ready three cycles after read_req.
        c = cyc;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        push(K_RDY, 0, 0, c); push(K_RD, 0, 0, c + 1); push(K_DONE, 0, 0, c + 5);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(1);
        chk("wait_busy", int'(bus.busy), 1);
        chk("wait_grant", int'(bus.grant_id), 0);
        tick(2);
        bus.ace_ready = 1'b1;
        tick(1);
        bus.ace_ready = 1'b0;
        tick(1);

        // Reserved op from req1: no command, done+err next cycle.
        c = cyc;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b11;
        push(K_RDY, 1, 0, c); push(K_DONE, 1, 1, c + 1);
        tick(1);
        bus.req1_valid = 1'b0;
        chk("rsvd_busy", int'(bus.busy), 1);
        tick(1);

        // Invalid op with no ace_ready: timeout after four WAIT cycles.
        c = cyc;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b10;
        push(K_RDY, 0, 0, c); push(K_INV, 0, 0, c + 1); push(K_DONE, 0, 1, c + 6);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(6);

        // ace_ready lands on the timeout cycle: completion wins, then stray ace_ready in IDLE.
        c = cyc;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b00;
        push(K_RDY, 1, 0, c); push(K_RD, 1, 0, c + 1); push(K_DONE, 1, 0, c + 6);
        tick(1);
        bus.req1_valid = 1'b0;
        tick(4);
        bus.ace_ready = 1'b1;
        tick(1);
        bus.ace_ready = 1'b0;
        tick(1);
        bus.ace_ready = 1'b1;
        tick(2);
        chk("stray_ace_busy", int'(bus.busy), 0);
        chk("stray_ace_grant", int'(bus.grant_id), 1);
        bus.ace_ready = 1'b0;
        tick(1);

        // Reset during WAIT aborts silently; a following read completes normally.
        c = cyc;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        push(K_RDY, 0, 0, c); push(K_RD, 0, 0, c + 1);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(2);
        rst = 1'b1;
        #1;
        chk("midreset_outputs", outs(), 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        c = cyc;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00;
        push(K_RDY, 0, 0, c); push(K_RD, 0, 0, c + 1); push(K_DONE, 0, 0, c + 3);
        tick(1);
        bus.req0_valid = 1'b0;
        tick(1);
        bus.ace_ready = 1'b1;
        tick(1);
        bus.ace_ready = 1'b0;
        tick(4);

        chk("events_outstanding", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", mon_checks + dir_checks, mon_errors + dir_errors);
        $finish;
    end
endmodule
